pcis_stream_bridge: RTL and testbench
=====================================

# pcis_stream_bridge

Parametrised AXI4-to-stream bridge on the DMA PCIS slave port. Host write bursts are split into narrow stream words for the compute pipeline. Each burst gets a proper B response carrying its ID. Host read bursts are served by packing narrow result words back into bus beats, with correct RID and RLAST per burst. It sits between the PCIS register slice and the accelerator's input/output FIFOs.

## Interface
- BUS_W, 512, AXI data width.
- STREAM_W, 64, stream word width; power of 2; must divide BUS_W. RATIO = BUS_W/STREAM_W.
- ID_W, 16, AXI ID width.
- Q_DEPTH, 4, maximum outstanding bursts per direction; power of 2, ≥2.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_awid / s_awlen / s_awvalid / s_awready  in/in/in/out  ID_W/8/1/1  write address. The address is not used.
- s_wdata / s_wlast / s_wvalid / s_wready  in/in/in/out  BUS_W/1/1/1  write data. WSTRB is not used; all beats are treated as full.
- s_bid / s_bresp / s_bvalid / s_bready  out/out/out/in  ID_W/2/1/1  write response.
- s_arid / s_arlen / s_arvalid / s_arready  in/in/in/out  ID_W/8/1/1  read address. The address is not used.
- s_rid / s_rdata / s_rresp / s_rlast / s_rvalid / s_rready  out/out/out/out/out/in  ID_W/BUS_W/2/1/1/1  read data.
- m_tdata / m_tlast / m_tvalid / m_tready  out/out/out/in  STREAM_W/1/1/1  downsized stream to the pipeline.
- s_tdata / s_tvalid / s_tready  in/in/out  STREAM_W/1/1  result stream from the pipeline.

## Operation
- Write queue: AW handshakes push awid into the AW FIFO.
  - awready = (AW FIFO count + B FIFO count) < Q_DEPTH. This guarantees the B FIFO never overflows.
- Downsizer:
  - A W handshake loads the beat into a holding register.
  - The beat is emitted as RATIO words, LSB word first, using word index idx from 0 to RATIO-1.
  - wready = AW FIFO not empty AND (holding register empty OR (idx==RATIO-1 AND m_tvalid AND m_tready)).
  - m_tlast = 1 on word RATIO-1 of a beat that was accepted with wlast=1.
- B path:
  - A W handshake with wlast=1 pops the AW FIFO and pushes that ID into the B FIFO in the same cycle.
  - s_bvalid = B FIFO not empty, with s_bid = head entry and s_bresp = 0.
  - A B handshake pops the FIFO.
- Read queue: AR handshakes push {arid, arlen} into the AR FIFO. arready = AR FIFO not full.
- Upsizer:
  - s_tdata words fill slot pcnt of the pack register, LSB first, where pcnt runs 0..RATIO-1.
  - When slot RATIO-1 is written, the pack register becomes full.
  - s_tready = !full OR (s_rvalid AND s_rready).
- R path:
  - s_rvalid = full AND AR FIFO not empty.
  - s_rid = head arid. s_rresp = 0.
  - s_rlast = (bcnt == head arlen), where bcnt counts beats within the current burst.
  - An R handshake clears full, or keeps it set if the same cycle completes a new fill (not possible for RATIO>1).
  - An R handshake increments bcnt. If rlast=1, bcnt resets to 0 and the AR FIFO pops.
- If no AR is pending, one full beat is held and s_tready deasserts. No data is dropped.
- Simultaneous push and pop on any FIFO: count is unchanged, and pop-then-push ordering is preserved.

## Timing
- Reset values:
  - awready, arready, wready, bvalid, rvalid, m_tvalid, m_tlast, s_tready = 0 while rst_n=0.
  - The first cycle after reset gives awready=1, arready=1, s_tready=1.
  - All counters and FIFOs are cleared.
- Reset mid-burst discards all queued IDs, partial beats and partial words. No B or R is issued for them.
- Write latency: W handshake in cycle N gives m_tvalid=1 with word 0 in cycle N+1.
  - With m_tready held high, words 0..RATIO-1 occupy cycles N+1..N+RATIO.
  - The next beat is accepted in cycle N+RATIO, giving gapless streaming.
- B latency: a wlast handshake in cycle N gives s_bvalid=1 in cycle N+1 at the earliest.
- Read latency: the s_tdata handshake filling slot RATIO-1 in cycle N gives s_rvalid in cycle N+1, provided an AR is queued.
- AW handshake in cycle N: W can be accepted in cycle N+1 at the earliest.
- All outputs are registered or decoded from registers only. There are no combinational paths from valid/ready inputs to the opposite ready/valid outputs, except s_tready←s_rready and wready←m_tready.

## Configuration
- PCIS_BRIDGE_STATS_EN defined:
  - Adds outputs stat_wr_beats and stat_rd_beats, both out, 32 bits.
  - They count W and R handshakes respectively, wrap at 2^32, and reset to 0.
- PCIS_BRIDGE_STATS_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
All scenarios use BUS_W=512, STREAM_W=64, RATIO=8.
- AW id=0x5 len=1, then two W beats with the second beat wlast, m_tready=1 → 16 words appear LSB first in consecutive cycles. m_tlast is high only on word 16. One B with bid=0x5, bresp=0.
- Four AWs (ids 1..4) with no W, then a fifth AW → awready drops after the 4th. Bursts complete, and Bs return in order 1,2,3,4. awready reasserts only after bready has popped a B.
- 24 stream words 0..23, then AR id=0x9 len=2 with rready=1 → three beats. Beat 0 holds words 7..0 (MSB..LSB). rid=0x9 on all beats, rlast only on beat 2.
- 8 stream words with no AR → s_tready=0 after the 8th word, and there is no rvalid. A later AR len=0 gives one beat with rlast=1, and s_tready reasserts.
- m_tready toggled 1/0 every cycle during a 4-beat write → all 32 words are delivered intact and in order. wready is never high while the holding register has undelivered words.
- Reset asserted mid-burst after word 3 → all valids are 0 the next cycle. A fresh AW/W then produces word 0 of the new beat, with no stale data and no stale B.

Source files
------------

// File: rtl/pcis_stream_bridge.sv
// -----------------------------------------------------------------------------
// pcis_stream_bridge
//
// AXI4 PCIS slave to narrow-stream bridge.
//   * Write side: AW IDs are queued. Each W beat is split into RATIO stream
//     words, LSB word first, on m_t*. The burst's ID moves to the B queue when
//     its wlast beat is accepted, and one B response is issued per burst.
//   * Read side: AR {id, len} pairs are queued. Result words on s_t* are
//     packed LSB first into bus beats. Those beats are returned on R with the
//     queued RID, and RLAST is asserted on beat number len of each burst.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   s_aw*                 write address (ID and length only; address unused)
//   s_w*                  write data (WSTRB not present; beats are full)
//   s_b*                  write response (always OKAY)
//   s_ar*                 read address (ID and length only)
//   s_r*                  read data (always OKAY)
//   m_t*                  downsized stream towards the compute pipeline
//   s_t*                  result stream from the compute pipeline
//   stat_wr_beats/stat_rd_beats
//                         W / R handshake counters, present only when
//                         PCIS_BRIDGE_STATS_EN is defined
//
// Build option: PCIS_BRIDGE_STATS_EN adds the statistics counters.
// -----------------------------------------------------------------------------

// Small synchronous FIFO used for the AW, B and AR queues. DEPTH must be a
// power of 2. The caller never pushes when the FIFO is full and never pops
// when it is empty.
module pcis_bridge_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Entry storage. Stale entries are never visible because the pointers are
    // reset, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping. A push and a pop in the same cycle
    // leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
endmodule

module pcis_stream_bridge #(
    parameter int BUS_W    = 512,
    parameter int STREAM_W = 64,
    parameter int ID_W     = 16,
    parameter int Q_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef PCIS_BRIDGE_STATS_EN
    output logic [31:0]         stat_wr_beats,
    output logic [31:0]         stat_rd_beats,
`endif
    input  logic [ID_W-1:0]     s_awid,
    input  logic [7:0]          s_awlen,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [BUS_W-1:0]    s_wdata,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_W-1:0]     s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_W-1:0]     s_arid,
    input  logic [7:0]          s_arlen,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_W-1:0]     s_rid,
    output logic [BUS_W-1:0]    s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [STREAM_W-1:0] m_tdata,
    output logic                m_tlast,
    output logic                m_tvalid,
    input  logic                m_tready,
    input  logic [STREAM_W-1:0] s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready
);
    localparam int               RATIO    = BUS_W / STREAM_W;
    localparam int               IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int               CNT_W    = $clog2(Q_DEPTH) + 1;
    localparam int               SUM_W    = CNT_W + 1;
    localparam int               AR_W     = ID_W + 8;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] Q_FULL   = CNT_W'(Q_DEPTH);
    localparam logic [SUM_W-1:0] Q_LIMIT  = SUM_W'(Q_DEPTH);
    localparam logic [7:0]       BCNT_ONE = 8'd1;

    // Low through reset, high from the first cycle after it; gates the
    // ready outputs so they read 0 while rst_n is asserted.
    logic alive_r;

    // Queue interfaces
    logic             aw_push_s, aw_pop_s;
    logic [ID_W-1:0]  aw_head_s;
    logic [CNT_W-1:0] aw_cnt_s;
    logic             b_push_s, b_pop_s;
    logic [ID_W-1:0]  b_head_s;
    logic [CNT_W-1:0] b_cnt_s;
    logic             ar_push_s, ar_pop_s;
    logic [AR_W-1:0]  ar_head_s;
    logic [CNT_W-1:0] ar_cnt_s;

    // Downsizer state
    logic [BUS_W-1:0] hold_data_r;
    logic             hold_valid_r;
    logic             hold_last_r;
    logic [IDX_W-1:0] idx_r;

    // Upsizer / read state
    logic [BUS_W-1:0] pack_r;
    logic [IDX_W-1:0] pcnt_r;
    logic             full_r;
    logic [7:0]       bcnt_r;

    // Decoded handshakes and ready/valid terms
    logic awready_s, wready_s, arready_s, tready_s;
    logic rvalid_s, rlast_s, bvalid_s;
    logic w_hs_s, m_hs_s, t_hs_s, r_hs_s, b_hs_s;
    logic unused_awlen_s;

    // awlen is not needed: a burst ends on wlast.
    assign unused_awlen_s = ^s_awlen;

    // Reset-exit flag used to hold the ready outputs low during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alive_r <= 1'b0;
        end else begin
            alive_r <= 1'b1;
        end
    end

    assign bvalid_s = (b_cnt_s != CNT_ZERO);
    assign rvalid_s = full_r && (ar_cnt_s != CNT_ZERO);
    assign rlast_s  = (bcnt_r == ar_head_s[7:0]);

    // Ready decode. AW is throttled on AW+B occupancy so every accepted burst
    // is guaranteed a B slot. wready and s_tready may look through to the
    // downstream ready so that streaming stays gapless.
    always_comb begin
        awready_s = 1'b0;
        arready_s = 1'b0;
        wready_s  = 1'b0;
        tready_s  = 1'b0;
        if (alive_r) begin
            awready_s = (({1'b0, aw_cnt_s} + {1'b0, b_cnt_s}) < Q_LIMIT);
            arready_s = (ar_cnt_s != Q_FULL);
            wready_s  = (aw_cnt_s != CNT_ZERO) &&
                        (!hold_valid_r || ((idx_r == IDX_LAST) && m_tready));
            tready_s  = !full_r || (rvalid_s && s_rready);
        end else begin
            awready_s = 1'b0;
            arready_s = 1'b0;
            wready_s  = 1'b0;
            tready_s  = 1'b0;
        end
    end

    assign w_hs_s = s_wvalid && wready_s;
    assign m_hs_s = hold_valid_r && m_tready;
    assign t_hs_s = s_tvalid && tready_s;
    assign r_hs_s = rvalid_s && s_rready;
    assign b_hs_s = bvalid_s && s_bready;

    assign aw_push_s = s_awvalid && awready_s;
    assign aw_pop_s  = w_hs_s && s_wlast;
    assign b_push_s  = aw_pop_s;
    assign b_pop_s   = b_hs_s;
    assign ar_push_s = s_arvalid && arready_s;
    assign ar_pop_s  = r_hs_s && rlast_s;

    pcis_bridge_fifo #(.W(ID_W), .DEPTH(Q_DEPTH), .CNT_W(CNT_W)) u_aw_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (aw_push_s),
        .pop   (aw_pop_s),
        .din   (s_awid),
        .head  (aw_head_s),
        .count (aw_cnt_s)
    );

    pcis_bridge_fifo #(.W(ID_W), .DEPTH(Q_DEPTH), .CNT_W(CNT_W)) u_b_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (b_push_s),
        .pop   (b_pop_s),
        .din   (aw_head_s),
        .head  (b_head_s),
        .count (b_cnt_s)
    );

    pcis_bridge_fifo #(.W(AR_W), .DEPTH(Q_DEPTH), .CNT_W(CNT_W)) u_ar_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ar_push_s),
        .pop   (ar_pop_s),
        .din   ({s_arid, s_arlen}),
        .head  (ar_head_s),
        .count (ar_cnt_s)
    );

    // Holding register data; only meaningful while hold_valid_r is set.
    always_ff @(posedge clk) begin
        if (w_hs_s) begin
            hold_data_r <= s_wdata;
        end
    end

    // Downsizer control: a new beat restarts at word 0; the final word
    // handshake empties the holding register unless a new beat lands in the
    // same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid_r <= 1'b0;
            hold_last_r  <= 1'b0;
            idx_r        <= IDX_ZERO;
        end else if (w_hs_s) begin
            hold_valid_r <= 1'b1;
            hold_last_r  <= s_wlast;
            idx_r        <= IDX_ZERO;
        end else if (m_hs_s) begin
            if (idx_r == IDX_LAST) begin
                hold_valid_r <= 1'b0;
                idx_r        <= IDX_ZERO;
            end else begin
                idx_r <= idx_r + IDX_ONE;
            end
        end
    end

    // Pack register slots; slot pcnt_r receives the next result word.
    always_ff @(posedge clk) begin
        if (t_hs_s) begin
            pack_r[int'(pcnt_r) * STREAM_W +: STREAM_W] <= s_tdata;
        end
    end

    // Upsizer control. Filling the last slot sets full; an R handshake clears
    // it unless the same cycle completes another fill (only when RATIO is 1).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_r <= IDX_ZERO;
            full_r <= 1'b0;
        end else begin
            if (t_hs_s) begin
                pcnt_r <= (pcnt_r == IDX_LAST) ? IDX_ZERO : (pcnt_r + IDX_ONE);
            end
            if (t_hs_s && (pcnt_r == IDX_LAST)) begin
                full_r <= 1'b1;
            end else if (r_hs_s) begin
                full_r <= 1'b0;
            end
        end
    end

    // Beat counter within the current read burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcnt_r <= 8'd0;
        end else if (r_hs_s) begin
            bcnt_r <= rlast_s ? 8'd0 : (bcnt_r + BCNT_ONE);
        end
    end

`ifdef PCIS_BRIDGE_STATS_EN
    logic [31:0] stat_wr_r;
    logic [31:0] stat_rd_r;

    // Free-running W and R handshake counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_wr_r <= 32'd0;
            stat_rd_r <= 32'd0;
        end else begin
            if (w_hs_s) begin
                stat_wr_r <= stat_wr_r + 32'd1;
            end
            if (r_hs_s) begin
                stat_rd_r <= stat_rd_r + 32'd1;
            end
        end
    end

    assign stat_wr_beats = stat_wr_r;
    assign stat_rd_beats = stat_rd_r;
`endif

    assign s_awready = awready_s;
    assign s_wready  = wready_s;
    assign s_arready = arready_s;
    assign s_tready  = tready_s;

    assign s_bvalid  = bvalid_s;
    assign s_bid     = b_head_s;
    assign s_bresp   = 2'b00;

    assign s_rvalid  = rvalid_s;
    assign s_rid     = ar_head_s[AR_W-1:8];
    assign s_rdata   = pack_r;
    assign s_rresp   = 2'b00;
    assign s_rlast   = rlast_s;

    assign m_tvalid  = hold_valid_r;
    assign m_tdata   = hold_data_r[int'(idx_r) * STREAM_W +: STREAM_W];
    assign m_tlast   = hold_valid_r && hold_last_r && (idx_r == IDX_LAST);
endmodule

// File: tb/tb_pcis_stream_bridge.sv
// -----------------------------------------------------------------------------
// tb_pcis_stream_bridge
//
// Randomized self-checking bench for pcis_stream_bridge (512/64 bits, RATIO 8).
// A queue-based reference model tracks the expected stream words, B IDs and
// R beats. Inputs are driven 1 time unit after the rising edge, and ready
// inputs are sampled 4 units after it. Monitors run on the falling edge.
// -----------------------------------------------------------------------------
module tb_pcis_stream_bridge;
    localparam int BUS_W    = 512;
    localparam int STREAM_W = 64;
    localparam int ID_W     = 16;
    localparam int Q_DEPTH  = 4;
    localparam int RATIO    = BUS_W / STREAM_W;
    localparam int LIM      = 300;

    logic clk = 1'b0;
    logic rst_n;
    logic [ID_W-1:0] s_awid, s_bid, s_arid, s_rid;
    logic [7:0] s_awlen, s_arlen;
    logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic [BUS_W-1:0] s_wdata, s_rdata;
    logic [1:0] s_bresp, s_rresp;
    logic s_bvalid, s_bready, s_arvalid, s_arready;
    logic s_rlast, s_rvalid, s_rready;
    logic [STREAM_W-1:0] m_tdata, s_tdata;
    logic m_tlast, m_tvalid, m_tready, s_tvalid, s_tready;
`ifdef PCIS_BRIDGE_STATS_EN
    logic [31:0] stat_wr_beats, stat_rd_beats;
`endif

    always #5 clk = ~clk;

    pcis_stream_bridge #(.BUS_W(BUS_W), .STREAM_W(STREAM_W), .ID_W(ID_W), .Q_DEPTH(Q_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef PCIS_BRIDGE_STATS_EN
        .stat_wr_beats(stat_wr_beats), .stat_rd_beats(stat_rd_beats),
`endif
        .s_awid(s_awid), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [STREAM_W-1:0] data; logic last; } word_t;
    typedef struct { logic [ID_W-1:0] id; logic [7:0] len; } ar_t;

    word_t               exp_m[$];   // stream words still owed on m_t*
    logic [ID_W-1:0]     aw_q[$];    // accepted AW IDs awaiting wlast
    logic [ID_W-1:0]     exp_b[$];   // B IDs owed, in order
    logic [STREAM_W-1:0] tw_q[$];    // result words accepted, not yet returned
    ar_t                 exp_ar[$];  // read bursts outstanding
    int r_idx = 0;

    int cyc = 0;
    int m_got = 0, m_base = 0, m_first_cyc = 0, m_last_cyc = 0;
    int b_got = 0, b_base = 0, r_got = 0, r_base = 0;
    int last_w_cyc = 0;
    int m_mode = 1, r_mode = 1;
    int wlen, rlen, n;
    logic [ID_W-1:0] rid_v;
    word_t mw;
    logic [BUS_W-1:0] rbeat;
    logic [BUS_W-1:0] w0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [BUS_W-1:0] rand_beat();
        logic [BUS_W-1:0] r;
        for (int i = 0; i < BUS_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic next_rdy(input int mode, input logic cur);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ~cur;
            default: return ($urandom_range(0, 1) == 1);
        endcase
    endfunction

    // Downstream ready drivers
    initial begin
        m_tready = 1'b0;
        s_rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_tready = next_rdy(m_mode, m_tready);
            s_rready = next_rdy(r_mode, s_rready);
        end
    end

    // Output monitors: compare every completed handshake with the model
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            if (m_got == m_base) m_first_cyc = cyc;
            m_last_cyc = cyc;
            m_got++;
            if (exp_m.size() > 0) begin
                mw = exp_m.pop_front();
                check_val("m_tdata", m_tdata, mw.data);
                check_val("m_tlast", m_tlast, mw.last);
            end
        end
        if (s_bvalid && s_bready) begin
            b_got++;
            if (exp_b.size() > 0) begin
                check_val("bid", s_bid, exp_b.pop_front());
                check_val("bresp", s_bresp, 2'b00);
            end
        end
        if (s_rvalid && s_rready) begin
            r_got++;
            if (exp_ar.size() > 0 && tw_q.size() >= RATIO) begin
                for (int i = 0; i < RATIO; i++) rbeat[i*STREAM_W +: STREAM_W] = tw_q.pop_front();
                check_val("rdata", s_rdata, rbeat);
                check_val("rid", s_rid, exp_ar[0].id);
                check_val("rlast", s_rlast, (r_idx == int'(exp_ar[0].len)));
                check_val("rresp", s_rresp, 2'b00);
                if (r_idx == int'(exp_ar[0].len)) begin
                    exp_ar.delete(0);
                    r_idx = 0;
                end else begin
                    r_idx++;
                end
            end
        end
    end

    // ---------------- drivers (enter and leave at posedge+1) ----------------
    task automatic send_aw(input logic [ID_W-1:0] id, input logic [7:0] len);
        int k = 0;
        s_awid = id; s_awlen = len; s_awvalid = 1'b1;
        #3;
        while (!s_awready && k < LIM) begin @(posedge clk); #4; k++; end
        check_val("aw_wait", (k < LIM), 1'b1);
        aw_q.push_back(id);
        @(posedge clk); #1;
        s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [BUS_W-1:0] data, input logic last);
        int k = 0;
        word_t w;
        s_wdata = data; s_wlast = last; s_wvalid = 1'b1;
        #3;
        while (!s_wready && k < LIM) begin @(posedge clk); #4; k++; end
        check_val("w_wait", (k < LIM), 1'b1);
        // wready may only rise when nothing, or only the word now leaving, is undelivered
        check_val("wready_hold", (exp_m.size() == 0) || (exp_m.size() == 1 && m_tvalid && m_tready), 1'b1);
        last_w_cyc = cyc;
        for (int i = 0; i < RATIO; i++) begin
            w.data = data[i*STREAM_W +: STREAM_W];
            w.last = last && (i == RATIO - 1);
            exp_m.push_back(w);
        end
        if (last && aw_q.size() > 0) exp_b.push_back(aw_q.pop_front());
        @(posedge clk); #1;
        s_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [ID_W-1:0] id, input logic [7:0] len);
        int k = 0;
        ar_t a;
        s_arid = id; s_arlen = len; s_arvalid = 1'b1;
        #3;
        while (!s_arready && k < LIM) begin @(posedge clk); #4; k++; end
        check_val("ar_wait", (k < LIM), 1'b1);
        a.id = id; a.len = len;
        exp_ar.push_back(a);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
    endtask

    task automatic send_t(input logic [STREAM_W-1:0] d);
        int k = 0;
        s_tdata = d; s_tvalid = 1'b1;
        #3;
        while (!s_tready && k < LIM) begin @(posedge clk); #4; k++; end
        check_val("t_wait", (k < LIM), 1'b1);
        tw_q.push_back(d);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_m.size() != 0 || exp_b.size() != 0 || exp_ar.size() != 0 || tw_q.size() != 0) && k < LIM) begin
            @(posedge clk); k++;
        end
        check_val(tag, (k < LIM), 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        rst_n = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_tvalid = 1'b0;
        s_bready = 1'b1; s_awid = '0; s_awlen = '0; s_wdata = '0; s_wlast = 1'b0;
        s_arid = '0; s_arlen = '0; s_tdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_outs", {s_awready, s_arready, s_wready, s_bvalid, s_rvalid, m_tvalid, m_tlast, s_tready}, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #4;
        check_val("post_rst_rdy", {s_awready, s_arready, s_tready, s_wready}, 4'b1110);
        @(posedge clk); #1;

        // 1: two-beat write, gapless words, one B
        m_mode = 1; m_base = m_got; b_base = b_got;
        send_aw(16'h0005, 8'd1);
        send_w(rand_beat(), 1'b0);
        w0 = BUS_W'(last_w_cyc);
        send_w(rand_beat(), 1'b1);
        drain("s1_drain");
        check_val("s1_words", m_got - m_base, 2 * RATIO);
        check_val("s1_latency", m_first_cyc - int'(w0), 1);
        check_val("s1_gapless", m_last_cyc - m_first_cyc, 2 * RATIO - 1);
        check_val("s1_bcount", b_got - b_base, 1);

        // 2: AW queue limit and in-order B return
        s_bready = 1'b0; b_base = b_got;
        for (int i = 1; i <= 4; i++) send_aw(16'(i), 8'd0);
        #3 check_val("s2_aw_full", s_awready, 1'b0);
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) send_w(rand_beat(), 1'b1);
        repeat (12) @(posedge clk);
        #4 check_val("s2_aw_blocked", {s_awready, s_bvalid}, 2'b01);
        @(posedge clk); #1;
        s_bready = 1'b1;
        #3 check_val("s2_aw_before_pop", s_awready, 1'b0);
        @(posedge clk); #4;
        check_val("s2_aw_after_pop", s_awready, 1'b1);
        @(posedge clk); #1;
        send_aw(16'h0006, 8'd0);
        send_w(rand_beat(), 1'b1);
        drain("s2_drain");
        check_val("s2_bcount", b_got - b_base, 5);

        // 3: 24 words then AR len=2
        r_mode = 1; r_base = r_got;
        fork
            for (int i = 0; i < 24; i++) send_t(STREAM_W'(i));
            begin repeat (12) @(posedge clk); #1; send_ar(16'h0009, 8'd2); end
        join
        drain("s3_drain");
        check_val("s3_beats", r_got - r_base, 3);

        // 4: full beat with no AR is held, then released by AR len=0
        r_base = r_got;
        for (int i = 0; i < RATIO; i++) send_t(STREAM_W'($urandom));
        repeat (3) @(posedge clk);
        #4 check_val("s4_held", {s_tready, s_rvalid}, 2'b00);
        @(posedge clk); #1;
        rid_v = ID_W'($urandom);
        send_ar(rid_v, 8'd0);
        drain("s4_drain");
        check_val("s4_beats", r_got - r_base, 1);
        #3 check_val("s4_tready_back", s_tready, 1'b1);
        @(posedge clk); #1;

        // 5: toggling m_tready over a 4-beat write
        m_mode = 2; m_base = m_got;
        send_aw(16'h00A4, 8'd3);
        for (int i = 0; i < 4; i++) send_w(rand_beat(), (i == 3));
        drain("s5_drain");
        check_val("s5_words", m_got - m_base, 4 * RATIO);

        // 6: randomized concurrent reads and writes with random backpressure
        for (int it = 0; it < 4; it++) begin
            wlen = $urandom_range(0, 2); rlen = $urandom_range(0, 2);
            m_mode = 3; r_mode = 3;
            m_base = m_got; r_base = r_got; b_base = b_got;
            rid_v = ID_W'($urandom);
            send_aw(ID_W'($urandom), 8'(wlen));
            fork
                for (int b = 0; b <= wlen; b++) send_w(rand_beat(), (b == wlen));
                for (int k = 0; k < (rlen + 1) * RATIO; k++) send_t(STREAM_W'($urandom));
                send_ar(rid_v, 8'(rlen));
            join
            drain("s6_drain");
            check_val("s6_words", m_got - m_base, (wlen + 1) * RATIO);
            check_val("s6_beats", r_got - r_base, rlen + 1);
            check_val("s6_bcount", b_got - b_base, 1);
        end
        m_mode = 1; r_mode = 1;

        // 7: reset in the middle of a beat
        send_aw(16'h0077, 8'd0);
        m_base = m_got;
        send_w(rand_beat(), 1'b1);
        n = 0;
        while ((m_got - m_base) < 4 && n < 100) begin @(posedge clk); #1; n++; end
        check_val("s7_reach_w3", (n < 100), 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_m.delete(); exp_b.delete(); aw_q.delete(); tw_q.delete(); exp_ar.delete(); r_idx = 0;
        #3 check_val("s7_valids", {m_tvalid, s_bvalid, s_rvalid, s_awready}, 4'b0000);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        m_base = m_got; b_base = b_got;
        send_aw(16'h0033, 8'd0);
        send_w(rand_beat(), 1'b1);
        drain("s7_drain");
        check_val("s7_words", m_got - m_base, RATIO);
        check_val("s7_bcount", b_got - b_base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
